// File: rtl/fp_arbiter.sv
// Fixed-priority arbiter: picks the highest-priority active request each cycle
// and registers a one-hot grant, its binary index and a valid flag.
module fp_arbiter #(
  parameter int unsigned NR       = 6,
  parameter int unsigned LSB_HIGH = 1,
  parameter int unsigned IW       = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NR-1:0] req,
  output logic [NR-1:0] grt,
  output logic          grt_vld,
  output logic [IW-1:0] grt_idx
);

  logic [NR-1:0] nxt_grt;
  logic          nxt_vld;
  logic [IW-1:0] nxt_idx;

  // Maps scan order to bit position so the first hit is always the winner.
  function automatic int unsigned scan_pos(input int unsigned i);
    return (LSB_HIGH != 0) ? i : (NR - 1 - i);
  endfunction

  // Priority scan; the valid flag doubles as the "already found" marker.
  always_comb begin
    nxt_grt = '0;
    nxt_vld = 1'b0;
    nxt_idx = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (!nxt_vld && req[scan_pos(i)]) begin
        nxt_grt[scan_pos(i)] = 1'b1;
        nxt_vld              = 1'b1;
        nxt_idx              = IW'(scan_pos(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grt     <= '0;
      grt_vld <= 1'b0;
      grt_idx <= '0;
    end else begin
      grt     <= nxt_grt;
      grt_vld <= nxt_vld;
      grt_idx <= nxt_idx;
    end
  end

endmodule

// File: tb/tb_fp_arbiter.sv
// Directed and random checks of fp_arbiter in forward, reverse and single-requester builds.
module tb_fp_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] req;
  logic [0:0] req1;

  logic [5:0] f_grt;  logic f_vld;  logic [2:0] f_idx;
  logic [5:0] r_grt;  logic r_vld;  logic [2:0] r_idx;
  logic [0:0] s_grt;  logic s_vld;  logic [0:0] s_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_arbiter #(.NR(6), .LSB_HIGH(1)) u_fwd (
    .clk(clk), .rst(rst), .req(req), .grt(f_grt), .grt_vld(f_vld), .grt_idx(f_idx)
  );
  fp_arbiter #(.NR(6), .LSB_HIGH(0)) u_rev (
    .clk(clk), .rst(rst), .req(req), .grt(r_grt), .grt_vld(r_vld), .grt_idx(r_idx)
  );
  fp_arbiter #(.NR(1), .LSB_HIGH(1)) u_one (
    .clk(clk), .rst(rst), .req(req1), .grt(s_grt), .grt_vld(s_vld), .grt_idx(s_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a new request between edges, then sample just after the next rising edge.
  task automatic step(input logic [5:0] r);
    @(negedge clk);
    req  = r;
    req1 = r[0];
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] low_bit(input logic [5:0] r);
    return r & (~r + 6'd1);
  endfunction

  function automatic logic [5:0] high_bit(input logic [5:0] r);
    logic [5:0] g;
    g = '0;
    for (int k = 5; k >= 0; k--) begin
      if (r[k] && g == 6'd0) g[k] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [2:0] pos_of(input logic [5:0] g);
    logic [2:0] p;
    p = '0;
    for (int k = 0; k < 6; k++) begin
      if (g[k]) p = 3'(k);
    end
    return p;
  endfunction

  logic [5:0] dreq [9] = '{6'b110001, 6'b111110, 6'b100100, 6'b111000, 6'b110000,
                           6'b100000, 6'b100001, 6'b101100, 6'b111111};
  logic [5:0] dgrt [9] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000,
                           6'b100000, 6'b000001, 6'b000100, 6'b000001};
  logic [2:0] didx [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd2, 3'd0};

  initial begin
    logic [5:0] r;
    logic [5:0] eg;
    rst  = 1'b1;
    req  = 6'b100000;
    req1 = 1'b0;

    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_grt", 32'(f_grt), 32'd0);
      chk("reset_vld", 32'(f_vld), 32'd0);
      chk("reset_idx", 32'(f_idx), 32'd0);
      chk("reset_rev_grt", 32'(r_grt), 32'd0);
    end

    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step(dreq[k]);
      chk($sformatf("dir_grt[%0d]", k), 32'(f_grt), 32'(dgrt[k]));
      chk($sformatf("dir_idx[%0d]", k), 32'(f_idx), 32'(didx[k]));
      chk($sformatf("dir_vld[%0d]", k), 32'(f_vld), 32'd1);
    end

    step(6'b000000);
    chk("idle_grt", 32'(f_grt), 32'd0);
    chk("idle_vld", 32'(f_vld), 32'd0);
    chk("idle_idx", 32'(f_idx), 32'd0);
    chk("idle_one_vld", 32'(s_vld), 32'd0);
    step(6'b000001);
    chk("wake_grt", 32'(f_grt), 32'b000001);
    chk("wake_vld", 32'(f_vld), 32'd1);
    chk("one_grt", 32'(s_grt), 32'd1);
    chk("one_idx", 32'(s_idx), 32'd0);

    step(6'b110001);
    chk("rev_grt_a", 32'(r_grt), 32'b100000);
    chk("rev_idx_a", 32'(r_idx), 32'd5);
    step(6'b001110);
    chk("rev_grt_b", 32'(r_grt), 32'b001000);
    chk("rev_idx_b", 32'(r_idx), 32'd3);
    chk("fwd_grt_b", 32'(f_grt), 32'b000010);

    step(6'b111111);
    chk("pre_rst_grt", 32'(f_grt), 32'b000001);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_grt", 32'(f_grt), 32'd0);
    chk("mid_rst_vld", 32'(f_vld), 32'd0);
    chk("mid_rst_idx", 32'(f_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_grt", 32'(f_grt), 32'b000001);
    chk("post_rst_vld", 32'(f_vld), 32'd1);

    for (int n = 0; n < 300; n++) begin
      r = 6'($urandom());
      step(r);
      eg = low_bit(r);
      chk("rnd_fwd_grt", 32'(f_grt), 32'(eg));
      chk("rnd_fwd_idx", 32'(f_idx), 32'(pos_of(eg)));
      chk("rnd_fwd_vld", 32'(f_vld), 32'(r != 6'd0));
      chk("rnd_onehot", 32'($onehot0(f_grt)), 32'd1);
      chk("rnd_subset", 32'(f_grt & ~r), 32'd0);
      eg = high_bit(r);
      chk("rnd_rev_grt", 32'(r_grt), 32'(eg));
      chk("rnd_rev_idx", 32'(r_idx), 32'(pos_of(eg)));
      chk("rnd_one_grt", 32'(s_grt), 32'(r[0]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
